// File: rtl/dma_pcie_byp_out_arb.sv
// Rotating-priority arbiter that merges NUM_REQ descriptor bypass-out streams into one registered port.
// Optional per-requester grant counters are enabled by defining DMA_BYP_OUT_ARB_STAT_EN.
module dma_pcie_byp_out_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DSC_W   = 256,
  parameter int unsigned CIDX_W  = 16
) (
  input  logic                       user_clk,
  input  logic                       user_reset_n,
  input  logic [NUM_REQ*DSC_W-1:0]   req_dsc,
  input  logic [NUM_REQ*CIDX_W-1:0]  req_cidx,
  input  logic [NUM_REQ-1:0]         req_vld,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic [DSC_W-1:0]           out_dsc,
  output logic [CIDX_W-1:0]          out_cidx,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       out_vld,
  input  logic                       out_rdy,
  input  logic                       stat_clr,
  output logic [NUM_REQ*32-1:0]      stat_cnt
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  logic [DSC_W-1:0]  out_dsc_q, out_dsc_d;
  logic [CIDX_W-1:0] out_cidx_q, out_cidx_d;
  logic [SRC_W-1:0]  out_src_q, out_src_d;
  logic              out_vld_q, out_vld_d;
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              load;
  logic              hi_any, lo_any, gnt_any;
  logic [SRC_W-1:0]  hi_idx, lo_idx, gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [DSC_W-1:0]  sel_dsc;
  logic [CIDX_W-1:0] sel_cidx;

  assign load = !out_vld_q || out_rdy;

  // Two-pass search: indices at/above rr_ptr take precedence over those below it.
  // Loops run downward so the lowest matching index in each pass wins.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_vld[i]) begin
        if (i >= int'(rr_ptr_q)) begin
          hi_any = 1'b1;
          hi_idx = SRC_W'(i);
        end else begin
          lo_any = 1'b1;
          lo_idx = SRC_W'(i);
        end
      end
    end
    gnt_any = hi_any || lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  always_comb begin
    gnt_oh   = '0;
    sel_dsc  = '0;
    sel_cidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_any && (gnt_idx == SRC_W'(i))) begin
        gnt_oh[i] = 1'b1;
        sel_dsc   = req_dsc[i*DSC_W +: DSC_W];
        sel_cidx  = req_cidx[i*CIDX_W +: CIDX_W];
      end
    end
  end

  // Ready is only offered when the output register can take the beat.
  assign req_rdy = (user_reset_n && load) ? gnt_oh : '0;

  always_comb begin
    out_dsc_d  = out_dsc_q;
    out_cidx_d = out_cidx_q;
    out_src_d  = out_src_q;
    out_vld_d  = out_vld_q;
    rr_ptr_d   = rr_ptr_q;
    if (load) begin
      if (gnt_any) begin
        out_dsc_d  = sel_dsc;
        out_cidx_d = sel_cidx;
        out_src_d  = gnt_idx;
        out_vld_d  = 1'b1;
        rr_ptr_d   = (gnt_idx == SRC_W'(NUM_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
      end else begin
        out_vld_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      out_dsc_q  <= '0;
      out_cidx_q <= '0;
      out_src_q  <= '0;
      out_vld_q  <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      out_dsc_q  <= out_dsc_d;
      out_cidx_q <= out_cidx_d;
      out_src_q  <= out_src_d;
      out_vld_q  <= out_vld_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_dsc  = out_dsc_q;
  assign out_cidx = out_cidx_q;
  assign out_src  = out_src_q;
  assign out_vld  = out_vld_q;

`ifdef DMA_BYP_OUT_ARB_STAT_EN
  logic [31:0] cnt_q [NUM_REQ];

  // Clear has priority over a same-cycle increment.
  always_ff @(posedge user_clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!user_reset_n || stat_clr) begin
        cnt_q[i] <= '0;
      end else if (req_vld[i] && req_rdy[i]) begin
        cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_cnt[i*32 +: 32] = cnt_q[i];
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_dma_pcie_byp_out_arb.sv
// Directed bench for dma_pcie_byp_out_arb: rotation, back-pressure hold, pointer wrap, reset, counters.
module tb_dma_pcie_byp_out_arb;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned DSC_W   = 256;
  localparam int unsigned CIDX_W  = 16;

  logic                       user_clk;
  logic                       user_reset_n;
  logic [NUM_REQ*DSC_W-1:0]   req_dsc;
  logic [NUM_REQ*CIDX_W-1:0]  req_cidx;
  logic [NUM_REQ-1:0]         req_vld;
  logic [NUM_REQ-1:0]         req_rdy;
  logic [DSC_W-1:0]           out_dsc;
  logic [CIDX_W-1:0]          out_cidx;
  logic [1:0]                 out_src;
  logic                       out_vld;
  logic                       out_rdy;
  logic                       stat_clr;
  logic [NUM_REQ*32-1:0]      stat_cnt;

  int errors = 0;
  int checks = 0;

  dma_pcie_byp_out_arb #(
    .NUM_REQ (NUM_REQ),
    .DSC_W   (DSC_W),
    .CIDX_W  (CIDX_W)
  ) dut (
    .user_clk     (user_clk),
    .user_reset_n (user_reset_n),
    .req_dsc      (req_dsc),
    .req_cidx     (req_cidx),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .out_dsc      (out_dsc),
    .out_cidx     (out_cidx),
    .out_src      (out_src),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .stat_clr     (stat_clr),
    .stat_cnt     (stat_cnt)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  // Counter expectation depends on whether the statistics build option is on.
  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef DMA_BYP_OUT_ARB_STAT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  function automatic logic [31:0] cnt(input int i);
    return stat_cnt[i*32 +: 32];
  endfunction

  logic [3:0] onehot;

  initial begin
    user_reset_n = 1'b0;
    req_vld      = '0;
    out_rdy      = 1'b0;
    stat_clr     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_dsc[i*DSC_W +: DSC_W]    = {8{32'hA000_0000 | 32'(i)}};
      req_cidx[i*CIDX_W +: CIDX_W] = 16'h0100 + 16'(i);
    end
    tick();
    req_vld = 4'b1111;
    out_rdy = 1'b1;
    #1;
    check_eq("rst_rdy", 64'(req_rdy), 64'h0);
    tick();
    check_eq("rst_vld",  64'(out_vld),  64'h0);
    check_eq("rst_src",  64'(out_src),  64'h0);
    check_eq("rst_cidx", 64'(out_cidx), 64'h0);
    check_eq("rst_dsc",  out_dsc[63:0], 64'h0);
    check_eq("rst_cnt",  64'(stat_cnt), 64'h0);

    // Full rotation with all requesters valid and no back-pressure.
    user_reset_n = 1'b1;
    #1;
    check_eq("rot_rdy0", 64'(req_rdy), 64'h1);
    for (int k = 0; k < 8; k++) begin
      tick();
      onehot = 4'b0001 << ((k + 1) % 4);
      check_eq($sformatf("rot_vld%0d", k),  64'(out_vld),  64'h1);
      check_eq($sformatf("rot_src%0d", k),  64'(out_src),  64'(k % 4));
      check_eq($sformatf("rot_cidx%0d", k), 64'(out_cidx), 64'(16'h0100 + 16'(k % 4)));
      check_eq($sformatf("rot_rdy%0d", k),  64'(req_rdy),  64'(onehot));
    end
    check_eq("rot_dsc_lo", out_dsc[63:0],    64'hA000_0003_A000_0003);
    check_eq("rot_dsc_hi", 64'(out_dsc[255:224]), 64'hA000_0003);
    for (int i = 0; i < NUM_REQ; i++) check_eq($sformatf("rot_cnt%0d", i), 64'(cnt(i)), 64'(exp_cnt(32'd2)));

    // Drain, then hold under back-pressure with only requester 2 valid.
    req_vld = 4'b0000;
    tick();
    check_eq("drain_vld", 64'(out_vld), 64'h0);
    req_vld = 4'b0100;
    out_rdy = 1'b0;
    req_cidx[2*CIDX_W +: CIDX_W] = 16'h0005;
    #1;
    check_eq("hold_rdy_pre", 64'(req_rdy), 64'h4);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq($sformatf("hold_vld%0d", k),  64'(out_vld),  64'h1);
      check_eq($sformatf("hold_cidx%0d", k), 64'(out_cidx), 64'h0005);
      check_eq($sformatf("hold_src%0d", k),  64'(out_src),  64'h2);
      check_eq($sformatf("hold_rdy%0d", k),  64'(req_rdy),  64'h0);
      req_cidx[2*CIDX_W +: CIDX_W] = 16'h0777;
    end
    check_eq("hold_dsc", out_dsc[63:0], 64'hA000_0002_A000_0002);
    check_eq("hold_cnt2", 64'(cnt(2)), 64'(exp_cnt(32'd3)));

    // rr_ptr is now 3; grant req 1 to move it to 2, then race req 1 and req 3.
    req_cidx[2*CIDX_W +: CIDX_W] = 16'h0102;
    req_vld = 4'b0010;
    out_rdy = 1'b1;
    #1;
    check_eq("wrap_rdy_a", 64'(req_rdy), 64'h2);
    tick();
    check_eq("wrap_src_a", 64'(out_src), 64'h1);
    req_vld = 4'b1010;
    #1;
    check_eq("wrap_rdy_b", 64'(req_rdy), 64'h8);
    tick();
    check_eq("wrap_src_b", 64'(out_src), 64'h3);
    check_eq("wrap_rdy_c", 64'(req_rdy), 64'h2);
    tick();
    check_eq("wrap_src_c", 64'(out_src), 64'h1);
    check_eq("wrap_cnt1", 64'(cnt(1)), 64'(exp_cnt(32'd4)));
    check_eq("wrap_cnt3", 64'(cnt(3)), 64'(exp_cnt(32'd3)));

    // Reset while holding a stalled output; rr_ptr was 2 beforehand.
    req_vld = 4'b0001;
    out_rdy = 1'b0;
    tick();
    check_eq("prerst_vld", 64'(out_vld), 64'h1);
    user_reset_n = 1'b0;
    #1;
    check_eq("midrst_rdy", 64'(req_rdy), 64'h0);
    tick();
    check_eq("postrst_vld",  64'(out_vld),  64'h0);
    check_eq("postrst_src",  64'(out_src),  64'h0);
    check_eq("postrst_cidx", 64'(out_cidx), 64'h0);
    check_eq("postrst_cnt",  64'(stat_cnt), 64'h0);
    user_reset_n = 1'b1;
    req_vld = 4'b1010;
    out_rdy = 1'b1;
    #1;
    check_eq("postrst_rdy", 64'(req_rdy), 64'h2);
    tick();
    check_eq("postrst_src1", 64'(out_src), 64'h1);
    check_eq("postrst_cnt1", 64'(cnt(1)), 64'(exp_cnt(32'd1)));

    // Counters: five transfers on req 0, clear asserted on the fifth.
    req_vld = 4'b0001;
    for (int k = 0; k < 4; k++) tick();
    check_eq("stat_cnt0_4", 64'(cnt(0)), 64'(exp_cnt(32'd4)));
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check_eq("stat_clr_all", 64'(stat_cnt), 64'h0);
    tick();
    check_eq("stat_cnt0_1", 64'(cnt(0)), 64'(exp_cnt(32'd1)));
    check_eq("stat_cnt1_0", 64'(cnt(1)), 64'h0);
    check_eq("stat_src", 64'(out_src), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
